alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Sequencer and arbiter that shares one 4-bit gate-level ALU, built from the nand2 cell library, between two requesters. It accepts requests from requester 0 and requester 1 and grants the ALU round-robin. It latches the winner's opcode and operands onto the ALU inputs and waits a fixed settle time for the transistor-level ALU. It then captures the result and carry and returns a one-cycle done pulse to the winner. It sits between the ALU datapath and its two clients (the instruction sequencer and the test/loader port).

## Interface
Parameters:
- WIDTH, 4, operand/result width
- OPW, 3, opcode width
- ALU_LAT, 2, settle cycles the ALU needs after its inputs change (legal 1..15)

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from requester 0 / 1
- op0 / op1  in  OPW  opcode from requester 0 / 1, valid while its req is high
- a0, b0 / a1, b1  in  WIDTH  operands from requester 0 / 1
- gnt0 / gnt1  out  1  one-cycle grant pulse; operands are captured on the edge that raises it
- done0 / done1  out  1  one-cycle completion pulse to the granted requester
- result  out  WIDTH  captured ALU output, held until the next capture
- carry  out  1  captured ALU carry-out, held until the next capture
- busy  out  1  high while an operation is in flight
- alu_op  out  OPW  registered opcode driven to the ALU
- alu_a, alu_b  out  WIDTH  registered operands driven to the ALU
- alu_y  in  WIDTH  ALU output
- alu_cout  in  1  ALU carry-out

## Operation
- States: IDLE and BUSY. A settle counter cnt is 4 bits wide. A priority pointer ptr marks the favoured requester (0 or 1).
- **Reset value of every output:** all outputs 0 (gnt*, done*, result, carry, busy, alu_*). State is IDLE, ptr=0, cnt=0.
- **IDLE, no req:** stay in IDLE. alu_* hold their last values.
- **IDLE, one req high:** grant that requester.
- **IDLE, both req high:** grant the requester selected by ptr.
- **On a grant:**
  - load alu_op/alu_a/alu_b from the winner's inputs;
  - pulse the winner's gnt;
  - set busy=1 and cnt=ALU_LAT-1;
  - go to BUSY;
  - set ptr to the loser (the other requester).
- **BUSY, cnt≠0:** decrement cnt. alu_* stay stable.
- **BUSY, cnt==0:**
  - capture result<=alu_y and carry<=alu_cout;
  - pulse done for the granted requester;
  - set busy=0 and go to IDLE.
- **Request rules:**
  - A requester holds req, op and operands until its gnt. After gnt its inputs are don't-care.
  - Dropping req while BUSY does not abort the operation; done is still pulsed.
  - A req still high in IDLE after done counts as a new request.
- **Fairness:** while both requesters hold req continuously, grants alternate 0,1,0,1…
- **Reset mid-operation:** return immediately to the reset values. The lost operation produces no done, and the requester must re-request.
- **Width rules:** result and carry pass through unmodified. The controller performs no arithmetic beyond the cnt decrement.

## Timing
- Grant latency: req high before edge E0 in IDLE → gnt high during cycle E0..E1.
- Result latency: capture occurs at edge E0+ALU_LAT; done and the new result are visible in cycle E0+ALU_LAT..E0+ALU_LAT+1.
- Throughput: the earliest next grant is at edge E0+ALU_LAT+1, so one operation completes every ALU_LAT+1 cycles.
- Done and grant never overlap for the same requester. At most one gnt and one done are high in any cycle.
- busy is high from edge E0 through edge E0+ALU_LAT.

## Structure
- Shared package alu_pkg holds:
  - WIDTH and OPW defaults;
  - the opcode constants (AND, OR, NAND, NOR, XOR, ADD, SUB, PASS);
  - the state encoding (IDLE=0, BUSY=1).
- One sub-module, rr_arb2: a 2-input round-robin arbiter with ptr update, purely combinational plus the ptr register.
- The top module holds the FSM, settle counter, operand registers and capture registers.

## Test plan
- **Reset:** assert rst_n=0 mid-BUSY → all outputs 0 at once; after release, no done appears.
- **Single request:** req0=1, op=ADD, a0=4'h7, b0=4'h9, ALU_LAT=2, ALU model returns y=4'h0, cout=1 → gnt0 at E0, done0 at E2, result=4'h0, carry=1, busy high E0..E2.
- **Contention:** req0 and req1 both held high from reset → grant order 0,1,0,1; grants spaced exactly 3 cycles apart; no gnt1 while busy.
- **Request dropped:** req1 dropped one cycle after gnt1 → done1 is still pulsed at E0+ALU_LAT, and no new grant follows for requester 1.
- **Operand stability:** change a0/b0 during BUSY → alu_a/alu_b unchanged until the next grant. With ALU_LAT=5, result appears exactly 5 edges after gnt.
- **Back-to-back:** req0 stays high through done0 with req1 low → re-grant to requester 0 at edge E0+ALU_LAT+1, and the new result replaces the old one.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: default widths, ALU opcodes
// and the controller state encoding.
package alu_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OPW_DEF   = 3;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the favoured requester on a
// tie and moves to the loser whenever a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic       o_vld,
  output logic       o_sel
);

  logic r_ptr;
  logic w_sel;

  always_comb begin
    w_sel = 1'b0;
    if (i_req == 2'b11) begin
      w_sel = r_ptr;
    end else if (i_req[1]) begin
      w_sel = 1'b1;
    end
  end

  assign o_vld = i_en & (|i_req);
  assign o_sel = w_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (o_vld) begin
      r_ptr <= ~w_sel;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one gate-level ALU between two requesters: round-robin grant, operand
// launch, fixed settle wait, then result capture and a done pulse to the winner.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic             r_owner;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             w_grant;
  logic             w_sel;
  logic             w_finish;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({req1, req0}),
    .i_en  (r_state == ST_IDLE),
    .o_vld (w_grant),
    .o_sel (w_sel)
  );

  assign w_finish = (r_state == ST_BUSY) && (r_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_finish) w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // Pulses default low each cycle; ALU inputs only move on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_owner  <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_grant) begin
        r_owner  <= w_sel;
        r_gnt0   <= ~w_sel;
        r_gnt1   <= w_sel;
        r_alu_op <= w_sel ? op1 : op0;
        r_alu_a  <= w_sel ? a1 : a0;
        r_alu_b  <= w_sel ? b1 : b0;
        r_cnt    <= LAT_M1;
      end else if (r_state == ST_BUSY) begin
        if (w_finish) begin
          r_result <= alu_y;
          r_carry  <= alu_cout;
          r_done0  <= ~r_owner;
          r_done1  <= r_owner;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign result = r_result;
  assign carry  = r_carry;
  assign busy   = (r_state == ST_BUSY);
  assign alu_op = r_alu_op;
  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed requests push expected grants and
// results into queues; monitors pop and compare whenever the DUT pulses gnt/done.
`timescale 1ns/1ps
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int LAT  = 2;
  localparam int LAT5 = 5;

  typedef struct {
    int         id;
    logic [3:0] y;
    logic       c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (ALU_LAT = 2)
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic       gnt0, gnt1, done0, done1, carry, busy, alu_cout;
  logic [3:0] result, alu_a, alu_b, alu_y;
  logic [2:0] alu_op;

  // second instance (ALU_LAT = 5), requester 0 only
  logic       req0_5 = 1'b0;
  logic [2:0] op0_5 = 3'd0;
  logic [3:0] a0_5 = 4'd0, b0_5 = 4'd0;
  logic       gnt0_5, gnt1_5, done0_5, done1_5, carry_5, busy_5, alu_cout_5;
  logic [3:0] result_5, alu_a_5, alu_b_5, alu_y_5;
  logic [2:0] alu_op_5;

  function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_NAND: return {1'b0, ~(a & b)};
      OP_NOR:  return {1'b0, ~(a | b)};
      OP_XOR:  return {1'b0, a ^ b};
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} + {1'b0, ~b} + 5'd1;
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_cout, alu_y}     = alu_f(alu_op, alu_a, alu_b);
  assign {alu_cout_5, alu_y_5} = alu_f(alu_op_5, alu_a_5, alu_b_5);

  alu_share_ctrl #(.WIDTH(4), .OPW(3), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .result(result), .carry(carry), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_cout(alu_cout)
  );

  alu_share_ctrl #(.WIDTH(4), .OPW(3), .ALU_LAT(LAT5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req0(req0_5), .req1(1'b0), .op0(op0_5), .op1(3'd0),
    .a0(a0_5), .b0(b0_5), .a1(4'd0), .b1(4'd0), .gnt0(gnt0_5), .gnt1(gnt1_5),
    .done0(done0_5), .done1(done1_5), .result(result_5), .carry(carry_5), .busy(busy_5),
    .alu_op(alu_op_5), .alu_a(alu_a_5), .alu_b(alu_b_5), .alu_y(alu_y_5), .alu_cout(alu_cout_5)
  );

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   gnt_cnt = 0;
  int   last_gnt_cyc = 0;
  int   g5 = 0;
  int   gq[$];
  exp_t dq[$];
  exp_t q5[$];
  exp_t e_m;
  exp_t e5;
  int   id_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor for the main instance
  always @(negedge clk) begin
    if (gnt0 || gnt1) begin
      gnt_cnt++;
      chk("gnt_both", gnt0 & gnt1, 0);
      chk("gnt_expected", gq.size() != 0, 1);
      if (gq.size() != 0) begin
        id_m = gq.pop_front();
        chk("gnt_id", gnt1, id_m);
      end
      chk("gnt_busy", busy, 1);
      last_gnt_cyc = cyc;
    end
    if (done0 || done1) begin
      done_cnt++;
      chk("done_both", done0 & done1, 0);
      chk("done_expected", dq.size() != 0, 1);
      if (dq.size() != 0) begin
        e_m = dq.pop_front();
        chk("done_id", done1, e_m.id);
        chk("result", result, e_m.y);
        chk("carry", carry, e_m.c);
      end
      chk("done_latency", cyc - last_gnt_cyc, LAT);
      chk("done_busy", busy, 0);
      chk("done_gnt_overlap", (done0 & gnt0) | (done1 & gnt1), 0);
    end
  end

  // monitor for the ALU_LAT=5 instance
  always @(negedge clk) begin
    if (gnt0_5) g5 = cyc;
    if (done0_5 || done1_5) begin
      chk("d5_expected", q5.size() != 0, 1);
      if (q5.size() != 0) begin
        e5 = q5.pop_front();
        chk("d5_result", result_5, e5.y);
        chk("d5_carry", carry_5, e5.c);
      end
      chk("d5_latency", cyc - g5, LAT5);
    end
  end

  task automatic wait_on(input int which, input int bound, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = gnt0;
        1:       hit = gnt1;
        2:       hit = done0;
        3:       hit = done1;
        default: hit = gnt0 | gnt1;
      endcase
    end
    chk({"wait_", nm}, hit, 1);
  endtask

  task automatic wait_drain(input int bound, input string nm);
    int i;
    i = 0;
    while ((dq.size() != 0 || gq.size() != 0 || busy) && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_drain"}, dq.size() + gq.size(), 0);
  endtask

  task automatic do_op(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] y, input logic c, input int hold, input string nm);
    int t0;
    gq.push_back(id);
    dq.push_back('{id, y, c});
    if (id == 0) begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
    else         begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
    t0 = cyc;
    wait_on(id, 10, {nm, "_gnt"});
    chk({nm, "_gnt_lat"}, cyc - t0, 1);
    chk({nm, "_alu_in"}, {alu_op, alu_a, alu_b}, {op, a, b});
    if (id == 0) begin op0 = ~op; a0 = ~a; b0 = ~b; if (hold == 0) req0 = 1'b0; end
    else         begin op1 = ~op; a1 = ~a; b1 = ~b; if (hold == 0) req1 = 1'b0; end
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      if (i == hold) begin
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
      end
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_alu_hold"}, {alu_op, alu_a, alu_b}, {op, a, b});
    end
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    wait_on(id + 2, 4, {nm, "_done"});
  endtask

  task automatic contend_setup(input int n);
    op0 = OP_SUB; a0 = 4'h5; b0 = 4'h3;
    op1 = OP_AND; a1 = 4'hC; b1 = 4'hA;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < n; k++) begin
      gq.push_back(0);
      gq.push_back(1);
      dq.push_back('{0, 4'h2, 1'b1});
      dq.push_back('{1, 4'h8, 1'b0});
    end
  endtask

  task automatic contend_run(input int n, input string nm);
    int c0, c1, prev;
    c0 = 0; c1 = 0; prev = -1;
    for (int k = 0; k < 2 * n; k++) begin
      wait_on(4, 3 * LAT + 6, {nm, "_gnt"});
      if (prev >= 0) chk({nm, "_spacing"}, cyc - prev, LAT + 1);
      prev = cyc;
      if (gnt0) begin c0++; if (c0 == n) req0 = 1'b0; end
      if (gnt1) begin c1++; if (c1 == n) req1 = 1'b0; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    wait_drain(20, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int td, gc, dc;
    bit hit;

    // reset values, with both requesters already asking
    contend_setup(2);
    repeat (3) @(negedge clk);
    chk("rst_pulses", {gnt0, gnt1, done0, done1, busy, carry}, 6'b0);
    chk("rst_result", result, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 11'b0);
    chk("rst_d5", {gnt0_5, done0_5, busy_5, result_5, alu_a_5}, 11'b0);
    rst_n = 1'b1;
    contend_run(2, "contend");

    do_op(0, OP_ADD, 4'h7, 4'h9, 4'h0, 1'b1, 0, "add");
    do_op(1, OP_XOR, 4'hA, 4'h3, 4'h9, 1'b0, 0, "xor");

    // req1 dropped one cycle after its grant
    do_op(1, OP_OR, 4'h5, 4'hA, 4'hF, 1'b0, 1, "drop");
    gc = gnt_cnt;
    repeat (4) @(negedge clk);
    chk("drop_no_regrant", gnt_cnt, gc);

    // back-to-back on requester 0
    gq.push_back(0); gq.push_back(0);
    dq.push_back('{0, 4'h6, 1'b0});
    dq.push_back('{0, 4'hE, 1'b0});
    op0 = OP_PASS; a0 = 4'h6; b0 = 4'h0; req0 = 1'b1;
    wait_on(0, 10, "b2b_g1");
    wait_on(2, LAT + 2, "b2b_d1");
    td = cyc;
    op0 = OP_SUB; a0 = 4'h3; b0 = 4'h5;
    wait_on(0, 3, "b2b_g2");
    chk("b2b_regrant", cyc - td, 1);
    req0 = 1'b0;
    wait_on(2, LAT + 2, "b2b_d2");
    chk("b2b_result", result, 4'hE);

    // operand stability and latency with ALU_LAT=5
    q5.push_back('{0, 4'h8, 1'b0});
    op0_5 = OP_NOR; a0_5 = 4'h3; b0_5 = 4'h4; req0_5 = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = gnt0_5;
    end
    chk("wait_d5_gnt", hit, 1);
    req0_5 = 1'b0; op0_5 = OP_PASS; a0_5 = 4'hF; b0_5 = 4'hF;
    for (int i = 1; i < LAT5; i++) begin
      @(negedge clk);
      chk("d5_alu_hold", {alu_op_5, alu_a_5, alu_b_5}, {OP_NOR, 4'h3, 4'h4});
      chk("d5_busy", busy_5, 1);
      chk("d5_no_early_done", done0_5, 0);
    end
    @(negedge clk);
    chk("d5_done", done0_5, 1);

    // reset in the middle of an operation
    gq.push_back(0);
    op0 = OP_AND; a0 = 4'hF; b0 = 4'h3; req0 = 1'b1;
    wait_on(0, 10, "rst_gnt");
    req0 = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pulses", {gnt0, gnt1, done0, done1, busy, carry}, 6'b0);
    chk("midrst_result", result, 0);
    chk("midrst_alu", {alu_op, alu_a, alu_b}, 11'b0);
    dc = done_cnt;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", done_cnt, dc);

    // pointer restarts at requester 0 after reset
    contend_setup(1);
    contend_run(1, "ptr_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
